// File: rtl/dram_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// dram_rr_arbiter_if
//
// Purpose:
//    Bundles every signal that passes between the round-robin DRAM arbiter
//    and its surroundings (the requesting cores and the shared DRAM
//    controller) so that the arbiter can be connected with a single port.
//
// Modports:
//    slave  - the arbiter itself: it serves the core requests and drives the
//             DRAM command fields.
//    master - the environment (cores + DRAM controller): drives requests,
//             w_init_done, dram_busy and dram_odata; observes the rest.
//
// Signal summary (NCORES cores, AW address bits, DW data bits, GW grant bits):
//    w_init_done             env -> arb  arbitration enabled while high
//    req_valid/we/lock       env -> arb  per-core request, write, bus lock
//    req_addr  [NCORES*AW]   env -> arb  core i at [i*AW +: AW]
//    req_wdata [NCORES*DW]   env -> arb  core i at [i*DW +: DW]
//    req_ctrl  [NCORES*3]    env -> arb  core i at [i*3 +: 3]
//    core_busy/core_done     arb -> env  per-core busy level / done pulse
//    core_rdata [DW]         arb -> env  read data of the last completion
//    grant [GW]              arb -> env  current / last granted core
//    dram_le, dram_we_t      arb -> env  launch strobe, write qualifier
//    dram_addr/wdata/ctrl    arb -> env  registered command fields
//    dram_busy, dram_odata   env -> arb  DRAM status and read data
// ---------------------------------------------------------------------------
interface dram_rr_arbiter_if #(
   parameter int NCORES = 4,
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int GW     = $clog2(NCORES)
) ();

   logic                 w_init_done;
   logic [NCORES-1:0]    req_valid;
   logic [NCORES-1:0]    req_we;
   logic [NCORES-1:0]    req_lock;
   logic [NCORES*AW-1:0] req_addr;
   logic [NCORES*DW-1:0] req_wdata;
   logic [NCORES*3-1:0]  req_ctrl;

   logic [NCORES-1:0]    core_busy;
   logic [NCORES-1:0]    core_done;
   logic [DW-1:0]        core_rdata;
   logic [GW-1:0]        grant;

   logic                 dram_le;
   logic                 dram_we_t;
   logic [AW-1:0]        dram_addr;
   logic [DW-1:0]        dram_wdata;
   logic [2:0]           dram_ctrl;
   logic                 dram_busy;
   logic [DW-1:0]        dram_odata;

   // Arbiter view: consumes requests and DRAM status, produces everything else.
   modport slave (
      input  w_init_done, req_valid, req_we, req_lock, req_addr, req_wdata,
             req_ctrl, dram_busy, dram_odata,
      output core_busy, core_done, core_rdata, grant, dram_le, dram_we_t,
             dram_addr, dram_wdata, dram_ctrl
   );

   // Environment view: the cores and the DRAM controller together.
   modport master (
      output w_init_done, req_valid, req_we, req_lock, req_addr, req_wdata,
             req_ctrl, dram_busy, dram_odata,
      input  core_busy, core_done, core_rdata, grant, dram_le, dram_we_t,
             dram_addr, dram_wdata, dram_ctrl
   );

endinterface

// File: rtl/dram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// dram_rr_arbiter
//
// Purpose:
//    Shares one DRAM controller between NCORES requesting cores using
//    round-robin arbitration. A winning core's command (address, write data,
//    control code, write flag) is captured into registers when it is granted,
//    launched with dram_le, and held stable until the DRAM finishes, at which
//    point the core receives a one-cycle done pulse and the read data.
//
// Ports:
//    CLK   in   single clock, all logic on the rising edge
//    RST   in   synchronous, active-high reset
//    bus   slave modport of dram_rr_arbiter_if (requests, per-core status,
//          grant index, DRAM command / status signals)
//
// Parameters:
//    NCORES  number of cores, 2..16 (need not be a power of two)
//    AW, DW  DRAM address / data widths
//    GW      grant index width, $clog2(NCORES)
//
// Configuration:
//    ARB_LOCK_EN  when defined, a core that completes a transaction with its
//                 req_lock high keeps the bus: the following arbitrations
//                 consider only that core until it drops req_lock. When not
//                 defined, req_lock is ignored and arbitration is pure
//                 round-robin.
// ---------------------------------------------------------------------------
module dram_rr_arbiter #(
   parameter int NCORES = 4,
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int GW     = $clog2(NCORES)
) (
   input logic           CLK,
   input logic           RST,
   dram_rr_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE
   } state_t;

   state_t         state;

   // First core examined by the next round-robin scan. It is kept separately
   // from grant because after reset the scan must start at core 0 while
   // grant also reads 0; after every grant it becomes grant+1 (mod NCORES).
   logic [GW-1:0]  scan_start;

   logic [GW-1:0]  winner;
   logic           winner_found;

`ifdef ARB_LOCK_EN
   // Set when the last completed transaction finished with its core's
   // req_lock high; cleared in IDLE once that core lets go of req_lock.
   logic           lock_flag;
`else
   // req_lock has no function in this build; folding it into a signal named
   // as unused keeps the intent explicit.
   logic           unused_req_lock;
   assign unused_req_lock = ^bus.req_lock;
`endif

   // Winner selection. The scan walks the cores starting at scan_start and
   // wrapping at NCORES (not at 2**GW, so non-power-of-two core counts wrap
   // correctly); the first valid core wins. While the bus is locked, only the
   // locking core may win, and nobody wins until it raises req_valid again.
   always_comb begin
      int idx;
      idx          = 0;
      winner       = '0;
      winner_found = 1'b0;
      for (int k = 0; k < NCORES; k++) begin
         idx = int'(scan_start) + k;
         if (idx >= NCORES) begin
            idx = idx - NCORES;
         end
         if (!winner_found && bus.req_valid[idx]) begin
            winner       = GW'(idx);
            winner_found = 1'b1;
         end
      end
`ifdef ARB_LOCK_EN
      if (lock_flag && bus.req_lock[bus.grant]) begin
         winner       = bus.grant;
         winner_found = bus.req_valid[bus.grant];
      end
`endif
   end

   // Main controller. IDLE arbitrates and captures the winner's command,
   // LAUNCH holds dram_le until the DRAM acknowledges by raising dram_busy,
   // WAIT_DONE waits for dram_busy to fall and then completes the core.
   // Every output is a register written here; core_done defaults to zero
   // each cycle so that it is a single-cycle pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= IDLE;
         scan_start     <= '0;
         bus.grant      <= '0;
         bus.dram_le    <= 1'b0;
         bus.dram_we_t  <= 1'b0;
         bus.dram_addr  <= '0;
         bus.dram_wdata <= '0;
         bus.dram_ctrl  <= '0;
         bus.core_busy  <= '0;
         bus.core_done  <= '0;
         bus.core_rdata <= '0;
`ifdef ARB_LOCK_EN
         lock_flag      <= 1'b0;
`endif
      end else begin
         bus.core_done <= '0;
         case (state)
            IDLE: begin
`ifdef ARB_LOCK_EN
               if (lock_flag && !bus.req_lock[bus.grant]) begin
                  lock_flag <= 1'b0;
               end
`endif
               // dram_busy high here means another agent owns the DRAM,
               // so no launch is attempted until it falls.
               if (bus.w_init_done && !bus.dram_busy && winner_found) begin
                  bus.grant      <= winner;
                  bus.dram_addr  <= bus.req_addr[winner*AW +: AW];
                  bus.dram_wdata <= bus.req_wdata[winner*DW +: DW];
                  bus.dram_ctrl  <= bus.req_ctrl[winner*3 +: 3];
                  bus.dram_we_t  <= bus.req_we[winner];
                  bus.core_busy  <= NCORES'(1) << winner;
                  bus.dram_le    <= 1'b1;
                  scan_start     <= (winner == GW'(NCORES - 1)) ? '0
                                                                : winner + GW'(1);
                  state          <= LAUNCH;
               end
            end

            LAUNCH: begin
               if (bus.dram_busy) begin
                  bus.dram_le <= 1'b0;
                  state       <= WAIT_DONE;
               end
            end

            WAIT_DONE: begin
               // Completion does not depend on the core still requesting:
               // a core that dropped req_valid mid-transaction still gets
               // its done pulse.
               if (!bus.dram_busy) begin
                  bus.core_rdata <= bus.dram_odata;
                  bus.core_done  <= NCORES'(1) << bus.grant;
                  bus.core_busy  <= '0;
`ifdef ARB_LOCK_EN
                  lock_flag      <= bus.req_lock[bus.grant];
`endif
                  state          <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dram_rr_arbiter.md
DRAM_RR_ARBITER -- requirements
Module: dram_rr_arbiter

Interface
REQ-001 Parameter NCORES, default 4, number of requesting cores (2..16, any value, not only a power of two).
REQ-002 Parameter AW, default 32, DRAM address width.
REQ-003 Parameter DW, default 32, DRAM data width.
REQ-004 Parameter GW, default $clog2(NCORES), grant index width.
REQ-005 CLK  in  1  single clock; all logic on its rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 w_init_done  in  1  arbitration enabled only while high.
REQ-008 req_valid  in  NCORES  per-core request level, held until that core's done pulse.
REQ-009 req_we  in  NCORES  per-core write (1) / read (0).
REQ-010 req_addr  in  NCORES*AW  per-core address, core i at [i*AW +: AW].
REQ-011 req_wdata  in  NCORES*DW  per-core write data.
REQ-012 req_ctrl  in  NCORES*3  per-core access size/control code.
REQ-013 req_lock  in  NCORES  per-core bus-lock request (used only under ARB_LOCK_EN).
REQ-014 core_busy  out  NCORES  per-core busy; high from acceptance until done.
REQ-015 core_done  out  NCORES  one-cycle completion pulse, one-hot.
REQ-016 core_rdata  out  DW  read data, valid in the cycle of core_done and held until next completion.
REQ-017 grant  out  GW  index of currently/last granted core.
REQ-018 dram_le, dram_we_t  out  1 each  DRAM launch strobe and write-type qualifier.
REQ-019 dram_addr, dram_wdata, dram_ctrl  out  AW, DW, 3  registered DRAM command fields.
REQ-020 dram_busy  in  1;  dram_odata  in  DW.

Function
REQ-021 FSM states IDLE, LAUNCH, WAIT_DONE; all outputs registered.
REQ-022 IDLE: when w_init_done && !dram_busy && any req_valid, the arbiter SHALL select a winner, latch grant, command fields and we, set core_busy[winner], assert dram_le, go to LAUNCH.
REQ-023 Winner = first valid core scanning grant+1, grant+2, ... modulo NCORES (round-robin); after reset the scan starts at core 0.
REQ-024 LAUNCH: dram_le held high until dram_busy sampled high; then dram_le<=0, go to WAIT_DONE.
REQ-025 WAIT_DONE: on dram_busy low, core_rdata<=dram_odata, core_done[grant] pulses, core_busy[grant]<=0, go to IDLE.
REQ-026 Latency: request in IDLE at cycle t -> dram_le high at t+1; new arbitration possible the cycle after done.
REQ-027 Command fields SHALL be stable from dram_le rise until done, regardless of req_* changes.
REQ-028 Deasserting req_valid mid-transaction SHALL NOT abort; done still pulses.
REQ-029 w_init_done low: no new grant; an in-flight transaction completes normally.
REQ-030 dram_busy high in IDLE (external owner): no launch until it falls.
REQ-031 Ungranted cores: core_busy=0, core_done=0; core_busy never high for more than one core.

Reset
REQ-032 RST high at any cycle, including mid-transaction: state<=IDLE, grant<=0, dram_le<=0, dram_we_t<=0, command fields<=0, core_busy<=0, core_done<=0, core_rdata<=0, lock flag<=0.
REQ-033 Upstream DRAM is expected to be reset in the same cycle; no recovery of aborted transaction.

Configuration
REQ-034 Macro ARB_LOCK_EN defined: if req_lock[grant] is high at done, the lock flag is set and the next IDLE grants only core grant (waiting until it requests) while req_lock[grant] stays high; lock released when req_lock[grant] sampled low in IDLE, round-robin resumes at grant+1.
REQ-035 ARB_LOCK_EN undefined: req_lock ignored, no lock flag, pure round-robin.

Verification
REQ-036 Single core 2 read, addr 0x1000, DRAM busy 3 cycles, odata 0xDEADBEEF -> dram_le at t+1, core_done[2] once, core_rdata 0xDEADBEEF, grant 2.
REQ-037 All 4 cores request continuously after reset -> grant order 0,1,2,3,0 with exactly one done each per round.
REQ-038 NCORES=3, cores 0 and 2 request, grant=2 -> next grant 0 (wrap), then 2.
REQ-039 Core 1 write 0x12345678 to 0x2000, req_wdata changed after launch -> dram_wdata stays 0x12345678 until done.
REQ-040 RST pulsed while in WAIT_DONE -> next cycle state IDLE, dram_le 0, core_busy 0, no done pulse.
REQ-041 ARB_LOCK_EN, core 1 lock high for 3 transactions while core 0 requests -> grants 1,1,1 then 0; without macro -> 1,0,1,0.
